hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 6-bit-PC pipelined core; the driving end of the program counter's hazard/flush interface. Detects read-after-write data hazards between ID and EX/MEM and taken branches resolved in EX, then drives the hazard request that makes the PC unit reset fetch and raise its flush flag. It consumes that flush flag as an acknowledgement, then issues a one-cycle redirect to the branch target. It also drives IF/ID stall and ID/EX bubble controls.

## Interface
- REG_AW, 3, register-address width; register 0 is hard-wired zero.
- PC_W, 6, PC width; matches the PC unit.
- STALL_CYC, 1, bubble cycles per data hazard, legal range 1..15.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_valid_in  in  1  ID stage holds a real instruction.
- id_rs_in  in  REG_AW  ID source register 1.
- id_rt_in  in  REG_AW  ID source register 2.
- ex_rd_in  in  REG_AW  EX destination register.
- ex_wr_in  in  1  EX instruction writes a register.
- ex_load_in  in  1  EX instruction is a load.
- mem_rd_in  in  REG_AW  MEM destination register.
- mem_wr_in  in  1  MEM instruction writes a register.
- br_taken_in  in  1  branch resolved taken in EX, valid one cycle.
- br_target_in  in  PC_W  branch target, valid with br_taken_in.
- flush_in  in  1  flush flag returned by the PC unit.
- h_out  out  1  hazard request to the PC unit.
- stall_out  out  1  hold PC/IF-ID.
- bubble_out  out  1  insert NOP into ID/EX.
- redirect_valid_out  out  1  redirect_pc_out is valid.
- redirect_pc_out  out  PC_W  PC to load after flush.
- hazard_cnt_out  out  8  saturating hazard event count.

## Operation
- match(rd) = id_valid_in & rd != 0 & (id_rs_in == rd | id_rt_in == rd).
- data_hz is the data-hazard condition; its definition is set by Configuration.
- FSM states:
  - IDLE: br_taken_in goes to FLUSH and latches br_target_in. Otherwise data_hz goes to STALL and loads cnt = STALL_CYC. Otherwise stay in IDLE.
  - STALL: stall_out = bubble_out = 1. cnt decrements each cycle; the state returns to IDLE after the cycle in which cnt == 1. br_taken_in during STALL goes to FLUSH, latches the target and abandons the stall.
  - FLUSH: h_out = 1. Goes to REDIRECT on the first cycle flush_in == 1 is sampled. Otherwise stays in FLUSH indefinitely. br_taken_in is ignored here.
  - REDIRECT: redirect_valid_out = 1 and redirect_pc_out = latched target for exactly one cycle, then IDLE. br_taken_in is ignored.
- Priority on simultaneous events: branch over data hazard.
- hazard_cnt_out increments by 1 on each entry into STALL or FLUSH. It holds at 255 with no wrap.
- redirect_pc_out holds the last latched target while redirect_valid_out is low.

## Timing
- State is registered. All outputs are Moore decodes of state, except redirect_pc_out and hazard_cnt_out, which are registers.
- Latency: a condition sampled at edge N drives outputs after edge N.
- Data hazard: stall_out and bubble_out are high for exactly STALL_CYC cycles.
- Branch: h_out is high for at least 1 cycle. The PC unit answers flush_in combinationally in the same cycle, so the minimum sequence is 1 FLUSH cycle, then 1 REDIRECT cycle.
- Reset: rst_n low at any edge, in any state, gives state IDLE, cnt = 0, target = 0, hazard_cnt_out = 0. All outputs are 0 after that edge.
- A branch or hazard sampled in the same cycle as rst_n low is discarded.

## Configuration
- HAZARD_FWD_EN defined: a forwarding network exists. data_hz = ex_load_in & ex_wr_in & match(ex_rd_in), so only load-use hazards stall.
- HAZARD_FWD_EN undefined: no forwarding. data_hz = (ex_wr_in & match(ex_rd_in)) | (mem_wr_in & match(mem_rd_in)).

## Structure
- Package hazard_pkg holds:
  - the state enum: IDLE, STALL, FLUSH, REDIRECT;
  - the REG_ZERO constant;
  - the hazard-count width and saturation constant.
- One sub-module, hazard_cmp: combinational match(rd), instantiated once per producing stage (EX, MEM).

## Test plan
- Load-use, FWD_EN, STALL_CYC = 1: ex_load_in = 1, ex_rd_in = 3, id_rs_in = 3 -> stall_out and bubble_out high for 1 cycle; hazard_cnt_out = 1.
- Branch: br_taken_in = 1, br_target_in = 6'h2A, PC unit model returns flush_in -> h_out high 1 cycle, then redirect_valid_out high 1 cycle with redirect_pc_out = 6'h2A, then IDLE.
- Simultaneous branch and data hazard -> FLUSH taken, no stall cycle. Branch during STALL with STALL_CYC = 4 -> stall aborts and h_out rises on the next cycle.
- rd = 0 match, and id_valid_in = 0 with a matching rd -> no stall. FWD_EN undefined, mem_wr_in = 1, mem_rd_in = 5, id_rt_in = 5 -> stall.
- rst_n low during FLUSH with flush_in held low -> all outputs 0 after that edge; no redirect follows.
- 300 back-to-back hazards -> hazard_cnt_out saturates at 255.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STALL    = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } hz_state_e;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned HCNT_W   = 8;
    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;

endpackage

// File: rtl/hazard_cmp.sv
// Register-match comparator: ID source operands against one producing stage's destination.
module hazard_cmp
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 3
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] rd,
    output logic              match_c
);

    // Register zero never carries a dependency.
    assign match_c = id_valid && (rd != REG_AW'(REG_ZERO)) && ((id_rs == rd) || (id_rt == rd));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, branch flush handshake with the PC unit, redirect.
// Optional macro HAZARD_FWD_EN: with forwarding present only load-use hazards stall.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW    = 3,
    parameter int unsigned PC_W      = 6,
    parameter int unsigned STALL_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_in,
    input  logic [REG_AW-1:0] id_rs_in,
    input  logic [REG_AW-1:0] id_rt_in,
    input  logic [REG_AW-1:0] ex_rd_in,
    input  logic              ex_wr_in,
    input  logic              ex_load_in,
    input  logic [REG_AW-1:0] mem_rd_in,
    input  logic              mem_wr_in,
    input  logic              br_taken_in,
    input  logic [PC_W-1:0]   br_target_in,
    input  logic              flush_in,
    output logic              h_out,
    output logic              stall_out,
    output logic              bubble_out,
    output logic              redirect_valid_out,
    output logic [PC_W-1:0]   redirect_pc_out,
    output logic [HCNT_W-1:0] hazard_cnt_out
);

    hz_state_e         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PC_W-1:0]   tgt_nxt;
    logic              cnt_inc;
    logic              ex_match, mem_match, data_hz;

    hazard_cmp #(.REG_AW(REG_AW)) u_cmp_ex (
        .id_valid (id_valid_in),
        .id_rs    (id_rs_in),
        .id_rt    (id_rt_in),
        .rd       (ex_rd_in),
        .match_c  (ex_match)
    );

    hazard_cmp #(.REG_AW(REG_AW)) u_cmp_mem (
        .id_valid (id_valid_in),
        .id_rs    (id_rs_in),
        .id_rt    (id_rt_in),
        .rd       (mem_rd_in),
        .match_c  (mem_match)
    );

`ifdef HAZARD_FWD_EN
    // Forwarding covers everything except a load result needed immediately.
    assign data_hz = ex_load_in && ex_wr_in && ex_match;
    logic unused_mem;
    assign unused_mem = &{1'b0, mem_wr_in, mem_match};
`else
    assign data_hz = (ex_wr_in && ex_match) || (mem_wr_in && mem_match);
    logic unused_load;
    assign unused_load = &{1'b0, ex_load_in};
`endif

    // Next state; a taken branch outranks a data hazard and abandons a stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tgt_nxt   = redirect_pc_out;
        cnt_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (br_taken_in) begin
                    state_nxt = FLUSH;
                    tgt_nxt   = br_target_in;
                    cnt_inc   = 1'b1;
                end else if (data_hz) begin
                    state_nxt = STALL;
                    cnt_nxt   = CNT_W'(STALL_CYC);
                    cnt_inc   = 1'b1;
                end
            end
            STALL: begin
                if (br_taken_in) begin
                    state_nxt = FLUSH;
                    tgt_nxt   = br_target_in;
                    cnt_nxt   = '0;
                    cnt_inc   = 1'b1;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            FLUSH: begin
                if (flush_in) begin
                    state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered decodes of the next state, so they track the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            redirect_pc_out    <= '0;
            hazard_cnt_out     <= '0;
            h_out              <= 1'b0;
            stall_out          <= 1'b0;
            bubble_out         <= 1'b0;
            redirect_valid_out <= 1'b0;
        end else begin
            state              <= state_nxt;
            cnt                <= cnt_nxt;
            redirect_pc_out    <= tgt_nxt;
            h_out              <= (state_nxt == FLUSH);
            stall_out          <= (state_nxt == STALL);
            bubble_out         <= (state_nxt == STALL);
            redirect_valid_out <= (state_nxt == REDIRECT);
            if (cnt_inc && (hazard_cnt_out != HCNT_MAX)) begin
                hazard_cnt_out <= hazard_cnt_out + HCNT_W'(1);
            end
        end
    end

endmodule
